// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: types and constants shared by the MIPS pipeline control blocks.
// The scoreboard slot type, the $0 register index and the all-zero control
// bundle used when a bubble is loaded into ID/EX.
package mips_pipe_pkg;

   // One scoreboard slot: destination register of an in-flight instruction.
   typedef struct packed {
      logic       v;
      logic [4:0] rd;
   } sb_slot_t;

   // Control bundle carried by ID/EX; a bubble is this struct with all bits 0.
   typedef struct packed {
      logic       RegWr;
      logic       RegDst;
      logic       ALUSrc;
      logic       MemWr;
      logic       MemtoReg;
      logic       Branch;
      logic [2:0] ALUctr;
   } ctrl_t;

   localparam logic [4:0] REG_ZERO   = 5'd0;
   localparam sb_slot_t   SLOT_EMPTY = '0;
   localparam ctrl_t      NOP_CTRL   = '0;

   // A slot blocks a read of register r when it holds a live write to r.
   // Register $0 is hardwired to zero, so writes to it never matter.
   function automatic logic slot_match(input sb_slot_t slot, input logic [4:0] r);
      return slot.v && (slot.rd == r) && (r != REG_ZERO);
   endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// hz_scoreboard: three-slot shift register mirroring the destination registers
// of the instructions in EX, MEM and WR, plus the match logic for the two
// source operands of the instruction currently in ID.
module hz_scoreboard
   import mips_pipe_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       take,
   input  sb_slot_t   ex_in,
   input  logic [4:0] src_a,
   input  logic [4:0] src_b,
   output logic       matchA,
   output logic       matchB
);

   sb_slot_t sb_ex_q, sb_ex_d;
   sb_slot_t sb_mem_q, sb_mem_d;
   sb_slot_t sb_wr_q, sb_wr_d;

   // Advance the slots one stage; a taken branch kills the instruction in EX.
   always_comb begin
      sb_ex_d  = ex_in;
      sb_mem_d = take ? SLOT_EMPTY : sb_ex_q;
      sb_wr_d  = sb_mem_q;
   end

   // Slot registers, cleared together on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_ex_q  <= SLOT_EMPTY;
         sb_mem_q <= SLOT_EMPTY;
         sb_wr_q  <= SLOT_EMPTY;
      end else begin
         sb_ex_q  <= sb_ex_d;
         sb_mem_q <= sb_mem_d;
         sb_wr_q  <= sb_wr_d;
      end
   end

   // WR participates because the register file is written at the end of WR,
   // so a read in ID during that same cycle still sees the old value.
   always_comb begin
      matchA = slot_match(sb_ex_q, src_a) || slot_match(sb_mem_q, src_a) ||
               slot_match(sb_wr_q, src_a);
      matchB = slot_match(sb_ex_q, src_b) || slot_match(sb_mem_q, src_b) ||
               slot_match(sb_wr_q, src_b);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the 5-stage MIPS core without forwarding.
// Stalls PC and IF/ID and bubbles ID/EX on any read-after-write hazard; on a
// branch taken in MEM it squashes the three younger instructions and steers
// the next PC to the branch target. Taken branches take priority over stalls.
module hazard_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_Ra,
   input  logic [4:0]       id_Rb,
   input  logic             id_useA,
   input  logic             id_useB,
   input  logic             id_RegWr,
   input  logic [4:0]       id_dst,
   input  logic             mem_Branch,
   input  logic             mem_Zero,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             idex_bubble,
   output logic             flush,
   output logic             npc_sel,
   output logic             id_valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             matchA;
   logic             matchB;
   logic             hazard;
   logic             take;
   sb_slot_t         ex_slot_d;
   logic             id_valid_q, id_valid_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   hz_scoreboard u_scoreboard (
      .clk    (clk),
      .rst    (rst),
      .take   (take),
      .ex_in  (ex_slot_d),
      .src_a  (id_Ra),
      .src_b  (id_Rb),
      .matchA (matchA),
      .matchB (matchB)
   );

   // Raw hazard and branch-taken conditions.
   always_comb begin
      take   = mem_Branch && mem_Zero;
      hazard = id_valid_q && ((id_useA && matchA) || (id_useB && matchB));
   end

   // Pipeline steering outputs; a taken branch overrides any stall.
   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_bubble = 1'b0;
      flush       = 1'b0;
      npc_sel     = 1'b0;
      if (take) begin
         flush   = 1'b1;
         npc_sel = 1'b1;
      end else if (hazard) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_bubble = 1'b1;
      end
   end

   // Destination entering EX: only a real register-writing instruction that
   // actually leaves ID this cycle is recorded.
   always_comb begin
      ex_slot_d = SLOT_EMPTY;
      if (!take && !hazard && id_valid_q && id_RegWr) begin
         ex_slot_d.v  = 1'b1;
         ex_slot_d.rd = id_dst;
      end
   end

   // Next IF/ID validity and saturating event counters.
   always_comb begin
      id_valid_d  = 1'b1;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (take) begin
         id_valid_d = 1'b0;
         if (flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
         end
      end else if (hazard) begin
         id_valid_d = id_valid_q;
         if (stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_valid_q  <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         id_valid_q  <= id_valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign id_valid  = id_valid_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl. A second instance with
// 2-bit counters shares the same stimulus to exercise counter saturation.
// The reference model tracks issued writers by the cycle they left ID.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_Ra, id_Rb, id_dst;
   logic        id_useA, id_useB, id_RegWr, mem_Branch, mem_Zero;
   logic        pc_stall, ifid_stall, idex_bubble, flush, npc_sel, id_valid;
   logic [15:0] stall_cnt, flush_cnt;
   logic        s_pc_stall, s_ifid_stall, s_idex_bubble, s_flush, s_npc_sel, s_id_valid;
   logic [1:0]  s_stall_cnt, s_flush_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_Ra(id_Ra), .id_Rb(id_Rb), .id_useA(id_useA),
      .id_useB(id_useB), .id_RegWr(id_RegWr), .id_dst(id_dst),
      .mem_Branch(mem_Branch), .mem_Zero(mem_Zero), .pc_stall(pc_stall),
      .ifid_stall(ifid_stall), .idex_bubble(idex_bubble), .flush(flush),
      .npc_sel(npc_sel), .id_valid(id_valid), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
   );

   hazard_ctrl #(.CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .id_Ra(id_Ra), .id_Rb(id_Rb), .id_useA(id_useA),
      .id_useB(id_useB), .id_RegWr(id_RegWr), .id_dst(id_dst),
      .mem_Branch(mem_Branch), .mem_Zero(mem_Zero), .pc_stall(s_pc_stall),
      .ifid_stall(s_ifid_stall), .idex_bubble(s_idex_bubble), .flush(s_flush),
      .npc_sel(s_npc_sel), .id_valid(s_id_valid), .stall_cnt(s_stall_cnt),
      .flush_cnt(s_flush_cnt)
   );

   // Reference model: a register written by an instruction that left ID in
   // cycle c is unreadable in cycles c+1 .. c+3 (EX, MEM, WR).
   typedef struct {
      int         cyc;
      logic [4:0] dst;
   } writer_t;

   writer_t writers[$];
   int      cyc;
   bit      m_valid;
   bit      m_hazard;
   bit      m_take;
   int      m_stall;
   int      m_flush;
   int      tests_run;
   int      failures;

   function automatic bit pending(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      foreach (writers[i]) begin
         if (writers[i].dst == r && (cyc - writers[i].cyc) <= 3) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [5:0] exp_vec();
      if (m_take)   return {3'b000, 2'b11, m_valid};
      if (m_hazard) return {3'b111, 2'b00, m_valid};
      return {5'b00000, m_valid};
   endfunction

   function automatic logic [5:0] dut_vec();
      return {pc_stall, ifid_stall, idex_bubble, flush, npc_sel, id_valid};
   endfunction

   function automatic logic [5:0] small_vec();
      return {s_pc_stall, s_ifid_stall, s_idex_bubble, s_flush, s_npc_sel, s_id_valid};
   endfunction

   function automatic logic [15:0] sat16(input int n);
      logic [15:0] v;
      v = n[15:0];
      return (n > 65535) ? 16'hFFFF : v;
   endfunction

   function automatic logic [1:0] sat2(input int n);
      logic [1:0] v;
      v = n[1:0];
      return (n > 3) ? 2'd3 : v;
   endfunction

   // Drive one cycle's inputs after the falling edge and evaluate the model.
   task automatic set_inputs(input bit r, input logic [4:0] ra, input logic [4:0] rb,
                             input bit ua, input bit ub, input bit wr,
                             input logic [4:0] dst, input bit br, input bit z);
      @(negedge clk);
      rst        = r;
      id_Ra      = ra;
      id_Rb      = rb;
      id_useA    = ua;
      id_useB    = ub;
      id_RegWr   = wr;
      id_dst     = dst;
      mem_Branch = br;
      mem_Zero   = z;
      #1;
      m_take   = br && z;
      m_hazard = m_valid && ((ua && pending(ra)) || (ub && pending(rb)));
   endtask

   // Advance the clock and the model by one cycle.
   task automatic tick();
      writer_t w;
      @(posedge clk);
      if (rst) begin
         writers.delete();
         m_valid = 1'b0;
         m_stall = 0;
         m_flush = 0;
      end else begin
         for (int i = writers.size() - 1; i >= 0; i--) begin
            if ((m_take && writers[i].cyc == cyc - 1) || (cyc - writers[i].cyc >= 3))
               writers.delete(i);
         end
         if (!m_take && !m_hazard && m_valid && id_RegWr) begin
            w.cyc = cyc;
            w.dst = id_dst;
            writers.push_back(w);
         end
         if (m_take) m_flush++;
         else if (m_hazard) m_stall++;
         m_valid = !m_take;
      end
      cyc++;
   endtask

   task automatic do_reset();
      set_inputs(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_reset();
      set_inputs(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      set_inputs(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tests_run++;
      if (dut_vec() !== 6'b000000) begin
         failures++;
         $display("[TB] FAIL reset_hold: got %b expected 000000", dut_vec());
      end
      tick();
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tests_run++;
      if (dut_vec() !== 6'b000000 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         failures++;
         $display("[TB] FAIL reset_first: got %b/%0d/%0d expected 000000/0/0",
                  dut_vec(), stall_cnt, flush_cnt);
      end
      tick();
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tests_run++;
      if (id_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_second_valid: got %b expected 1", id_valid);
      end
      tick();
   endtask

   task automatic test_load_use();
      int  stalls;
      bit  issued;
      do_reset();
      set_inputs(0, 0, 0, 1, 0, 1, 1, 0, 0);          // lw $1,0($0)
      tick();
      stalls = 0;
      issued = 0;
      for (int i = 0; i < 6 && !issued; i++) begin
         set_inputs(0, 1, 1, 1, 1, 1, 2, 0, 0);       // add $2,$1,$1
         tests_run++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL load_use_cycle%0d: got %b expected %b", i, dut_vec(), exp_vec());
         end
         if (pc_stall === 1'b1) stalls++;
         issued = !m_hazard;
         tick();
      end
      tests_run++;
      if (stalls != 3 || !issued) begin
         failures++;
         $display("[TB] FAIL load_use_stalls: got %0d expected 3", stalls);
      end
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tests_run++;
      if (stall_cnt !== 16'd3 || s_stall_cnt !== 2'd3) begin
         failures++;
         $display("[TB] FAIL load_use_stall_cnt: got %0d/%0d expected 3/3", stall_cnt, s_stall_cnt);
      end
      tick();
      set_inputs(0, 2, 0, 1, 0, 0, 0, 0, 0);          // reader of $2, add now in MEM
      tests_run++;
      if (pc_stall !== 1'b1) begin
         failures++;
         $display("[TB] FAIL load_use_add_issued: got %b expected 1", pc_stall);
      end
      tick();
   endtask

   task automatic test_distance();
      int  stalls;
      bit  issued;
      for (int d = 1; d <= 4; d++) begin
         do_reset();
         set_inputs(0, 0, 0, 1, 0, 1, 3, 0, 0);       // addi $3,$0,5
         tick();
         for (int n = 1; n < d; n++) begin
            set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);    // nop
            tick();
         end
         stalls = 0;
         issued = 0;
         for (int i = 0; i < 6 && !issued; i++) begin
            set_inputs(0, 3, 3, 1, 1, 1, 4, 0, 0);    // sub $4,$3,$3
            if (pc_stall === 1'b1) stalls++;
            issued = !m_hazard;
            tick();
         end
         tests_run++;
         if (stalls != 4 - d || !issued) begin
            failures++;
            $display("[TB] FAIL distance%0d_stalls: got %0d expected %0d", d, stalls, 4 - d);
         end
      end
      do_reset();
      set_inputs(0, 0, 0, 1, 0, 1, 0, 0, 0);          // addi $0,$0,5
      tick();
      set_inputs(0, 0, 0, 1, 1, 1, 4, 0, 0);          // sub $4,$0,$0
      tests_run++;
      if (pc_stall !== 1'b0) begin
         failures++;
         $display("[TB] FAIL zero_dst_no_stall: got %b expected 0", pc_stall);
      end
      tick();
   endtask

   task automatic test_branch();
      do_reset();
      set_inputs(0, 0, 0, 1, 1, 0, 0, 0, 0);          // beq $0,$0,+4
      tick();
      set_inputs(0, 0, 0, 1, 0, 1, 5, 0, 0);          // writes $5
      tick();
      set_inputs(0, 0, 0, 1, 0, 1, 6, 1, 1);          // writes $6, beq in MEM taken
      tests_run++;
      if (dut_vec() !== 6'b000111) begin
         failures++;
         $display("[TB] FAIL branch_take: got %b expected 000111", dut_vec());
      end
      tick();
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tests_run++;
      if (dut_vec() !== 6'b000000 || flush_cnt !== 16'd1) begin
         failures++;
         $display("[TB] FAIL branch_after: got %b/%0d expected 000000/1", dut_vec(), flush_cnt);
      end
      tick();
      set_inputs(0, 5, 6, 1, 1, 1, 7, 0, 0);          // reads squashed destinations
      tests_run++;
      if (pc_stall !== 1'b0) begin
         failures++;
         $display("[TB] FAIL branch_squash_no_write: got %b expected 0", pc_stall);
      end
      tick();
      set_inputs(0, 0, 0, 0, 0, 0, 0, 1, 0);          // branch not taken
      tests_run++;
      if (flush !== 1'b0 || npc_sel !== 1'b0) begin
         failures++;
         $display("[TB] FAIL branch_not_taken: got %b%b expected 00", flush, npc_sel);
      end
      tick();
   endtask

   task automatic test_branch_over_stall();
      do_reset();
      set_inputs(0, 0, 0, 1, 0, 1, 7, 0, 0);          // lw $7,0($0)
      tick();
      set_inputs(0, 0, 0, 1, 1, 0, 0, 0, 0);          // beq $0,$0,+4
      tick();
      set_inputs(0, 7, 7, 1, 1, 1, 8, 0, 0);          // add $8,$7,$7 stalls
      tests_run++;
      if (pc_stall !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bos_stalled: got %b expected 1", pc_stall);
      end
      tick();
      set_inputs(0, 7, 7, 1, 1, 1, 8, 1, 1);          // beq reaches MEM
      tests_run++;
      if (dut_vec() !== 6'b000111) begin
         failures++;
         $display("[TB] FAIL bos_flush_wins: got %b expected 000111", dut_vec());
      end
      tick();
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tests_run++;
      if (stall_cnt !== 16'd1 || flush_cnt !== 16'd1 || id_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bos_counts: got %0d/%0d/%b expected 1/1/0",
                  stall_cnt, flush_cnt, id_valid);
      end
      tick();
      set_inputs(0, 8, 8, 1, 1, 1, 9, 0, 0);          // reader of add destination
      tests_run++;
      if (pc_stall !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bos_add_discarded: got %b expected 0", pc_stall);
      end
      tick();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_inputs(0, 0, 0, 1, 0, 1, 9, 0, 0);
      tick();
      set_inputs(0, 9, 0, 1, 0, 1, 10, 0, 0);
      tick();
      set_inputs(1, 9, 0, 1, 0, 1, 10, 1, 1);         // reset during stall and take
      tick();
      set_inputs(0, 9, 0, 1, 0, 1, 10, 0, 0);
      tests_run++;
      if (dut_vec() !== 6'b000000 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         failures++;
         $display("[TB] FAIL reset_mid_stall: got %b/%0d/%0d expected 000000/0/0",
                  dut_vec(), stall_cnt, flush_cnt);
      end
      tick();
      set_inputs(0, 9, 0, 1, 0, 0, 0, 0, 0);
      tests_run++;
      if (pc_stall !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_mid_stall_clear: got %b expected 0", pc_stall);
      end
      tick();
   endtask

   task automatic test_saturation();
      bit issued;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         set_inputs(0, 0, 0, 1, 0, 1, 1, 0, 0);
         tick();
         issued = 0;
         for (int i = 0; i < 6 && !issued; i++) begin
            set_inputs(0, 1, 1, 1, 1, 1, 2, 0, 0);
            issued = !m_hazard;
            tick();
         end
      end
      for (int k = 0; k < 4; k++) begin
         set_inputs(0, 0, 0, 0, 0, 0, 0, 1, 1);
         tick();
      end
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tests_run++;
      if (stall_cnt !== 16'd6 || s_stall_cnt !== 2'd3) begin
         failures++;
         $display("[TB] FAIL sat_stall: got %0d/%0d expected 6/3", stall_cnt, s_stall_cnt);
      end
      tests_run++;
      if (flush_cnt !== 16'd4 || s_flush_cnt !== 2'd3) begin
         failures++;
         $display("[TB] FAIL sat_flush: got %0d/%0d expected 4/3", flush_cnt, s_flush_cnt);
      end
      tick();
   endtask

   task automatic test_random();
      logic [4:0] ra, rb, dst;
      bit         r, ua, ub, wr, br, z;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         r   = ($urandom_range(63) == 0);
         ra  = 5'($urandom_range(3));
         rb  = 5'($urandom_range(3));
         dst = 5'($urandom_range(3));
         ua  = 1'($urandom_range(1));
         ub  = 1'($urandom_range(1));
         wr  = ($urandom_range(3) != 0);
         br  = ($urandom_range(5) == 0);
         z   = 1'($urandom_range(1));
         set_inputs(r, ra, rb, ua, ub, wr, dst, br, z);
         tests_run++;
         if (dut_vec() !== exp_vec() || small_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL rand_outputs i=%0d: got %b/%b expected %b",
                     i, dut_vec(), small_vec(), exp_vec());
         end
         tests_run++;
         if (stall_cnt !== sat16(m_stall) || flush_cnt !== sat16(m_flush) ||
             s_stall_cnt !== sat2(m_stall) || s_flush_cnt !== sat2(m_flush)) begin
            failures++;
            $display("[TB] FAIL rand_counters i=%0d: got %0d/%0d/%0d/%0d expected %0d/%0d",
                     i, stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt, m_stall, m_flush);
         end
         tick();
      end
   endtask

   initial begin
      tests_run = 0;
      failures  = 0;
      cyc       = 0;
      m_valid   = 1'b0;
      m_stall   = 0;
      m_flush   = 0;
      m_hazard  = 1'b0;
      m_take    = 1'b0;
      rst = 1'b1; id_Ra = '0; id_Rb = '0; id_dst = '0; id_useA = 1'b0;
      id_useB = 1'b0; id_RegWr = 1'b0; mem_Branch = 1'b0; mem_Zero = 1'b0;
      test_reset();
      test_load_use();
      test_distance();
      test_branch();
      test_branch_over_stall();
      test_reset_mid_stall();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
